// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle radix-2 shift-and-add multiplier with signed/unsigned mode and
// valid/ready handshakes on operands and product.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               is_signed_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] y_o,
  output logic               busy_o
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    y_q, y_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic             last_step;

  // The magnitude of -2^(WIDTH-1) still fits in WIDTH unsigned bits.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  assign addend    = mag_b_q[0] ? (PW'(mag_a_q) << cnt_q) : '0;
  assign acc_sum   = acc_q + addend;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d   = acc_sum;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Negating a zero sum yields zero, so no negative zero can appear.
        if (last_step) begin
          y_d     = neg_q ? -acc_sum : acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign y_o         = y_q;

endmodule
